ps2_rx_fifo: RTL and testbench



---
 rtl/kbd_pkg.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 52 +++++
 rtl/ps2_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared keyboard-path definitions: deframer states, PS/2 frame geometry,
// default timeout for a 25 MHz system clock, and an odd-parity helper.
package kbd_pkg;

    localparam int unsigned PS2_FRAME_BITS      = 11;
    localparam int unsigned PS2_DATA_BITS       = 8;
    localparam int unsigned PS2_TIMEOUT_CYC_25M = 25000;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Generic first-word-fall-through byte FIFO.
// Ports: clk, rst (async, active-high); push/push_data write side;
// pop read side (ignored when empty); head = entry at read pointer
// (8'h00 when empty); empty/full status. A push while full is accepted
// only if a pop happens in the same cycle.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receive front end with scancode FIFO.
// Ports: clk25 system clock; reset_in async active-high reset;
// ps2_clk_i/ps2_data_i raw pins; code_o/code_valid_o/code_ready_i FIFO
// head handshake; frame_err_o pulse on bad start/parity/stop or timeout;
// overflow_o pulse when a good frame is dropped on a full FIFO;
// busy_o deframer not idle.
// Optional: define PS2_RX_ERRCNT_EN to add err_count_o, a saturating
// count of frame_err_o/overflow_o pulse cycles.
module ps2_rx_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC_25M,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk25,
    input  logic       reset_in,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    input  logic       code_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
`ifdef PS2_RX_ERRCNT_EN
    ,
    output logic [7:0] err_count_o
`endif
);

    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BW = $clog2(PS2_DATA_BITS);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic [FW-1:0] filt_cnt;
    logic       filt_clk;
    logic       filt_clk_d;
    logic       fall;
    logic       data_s;

    ps2_state_e state;
    logic [BW-1:0] bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic       par_bit;
    logic [TW-1:0] tmo_cnt;
    logic       fifo_push;

    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_c;

    assign data_s = data_sync[1];
    assign fall   = filt_clk_d & ~filt_clk;
    assign pop_c  = code_valid_o & code_ready_i;
    assign busy_o = (state != IDLE);

    // Two-flop synchronisers, idle bus level on reset.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    // Clock deglitch: level flips after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Deframer; a fall event always wins over a coincident timeout.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            fifo_push   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            fifo_push   <= 1'b0;
            frame_err_o <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s && odd_parity_ok(shreg, par_bit)) fifo_push   <= 1'b1;
                        else                                          frame_err_o <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state       <= IDLE;
                    frame_err_o <= 1'b1;
                    tmo_cnt     <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // A push into a full FIFO with no pop is dropped.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) overflow_o <= 1'b0;
        else          overflow_o <= fifo_push & fifo_full & ~pop_c;
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk25),
        .rst       (reset_in),
        .push      (fifo_push),
        .push_data (shreg),
        .pop       (pop_c),
        .head      (code_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign code_valid_o = ~fifo_empty;

`ifdef PS2_RX_ERRCNT_EN
    // Saturating error counter; one step per pulse cycle.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in)                                              err_count_o <= 8'h00;
        else if ((frame_err_o | overflow_o) && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'h01;
    end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: single frame, bad parity, glitch,
// timeout, overflow, full-with-pop and mid-frame reset.
module tb_ps2_rx_fifo;

    logic       clk25 = 1'b0;
    logic       reset_in = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       code_ready_i = 1'b0;
    logic       frame_err_o;
    logic       overflow_o;
    logic       busy_o;
`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_count_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int busy_seen = 0;

    ps2_rx_fifo dut (
        .clk25        (clk25),
        .reset_in     (reset_in),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
`ifdef PS2_RX_ERRCNT_EN
        ,
        .err_count_o  (err_count_o)
`endif
    );

    always #20 clk25 = ~clk25;

    // Pulse/level monitors sampled away from the active edge.
    always @(negedge clk25) begin
        if (frame_err_o) err_seen++;
        if (overflow_o)  ovf_seen++;
        if (busy_o)      busy_seen++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the first nbits of an 11-bit frame; data changes while clock is high.
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits, input int half);
        logic [10:0] frame;
        logic        par;
        par   = (~^b) ^ bad_par;
        frame = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = frame[i];
            wait_cyc(half);
            ps2_clk_i = 1'b0;
            wait_cyc(half);
            ps2_clk_i = 1'b1;
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(code_valid_o), 32'd1);
        chk({tag, "_code"}, 32'(code_o), 32'(exp));
        code_ready_i = 1'b1;
        wait_cyc(1);
        code_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_cyc(4);
        chk("rst_valid", 32'(code_valid_o), 32'd0);
        chk("rst_code", 32'(code_o), 32'h00);
        chk("rst_err", 32'(frame_err_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        reset_in = 1'b0;
        wait_cyc(20);

        // Single frame 8'h1C at 12.5 kHz
        send_bits(8'h1C, 1'b0, 11, 1000);
        wait_cyc(5);
        chk("f1c_valid", 32'(code_valid_o), 32'd1);
        chk("f1c_code", 32'(code_o), 32'h1C);
        chk("f1c_noerr", 32'(err_seen), 32'd0);
        code_ready_i = 1'b1;
        wait_cyc(1);
        code_ready_i = 1'b0;
        chk("f1c_pop_valid", 32'(code_valid_o), 32'd0);
        chk("f1c_pop_code", 32'(code_o), 32'h00);

        // Bad parity then good 8'hF0
        send_bits(8'h1C, 1'b1, 11, 20);
        wait_cyc(30);
        chk("bpar_err", 32'(err_seen), 32'd1);
        chk("bpar_empty", 32'(code_valid_o), 32'd0);
        send_bits(8'hF0, 1'b0, 11, 20);
        wait_cyc(30);
        pop_chk("ff0", 8'hF0);
        chk("ff0_empty", 32'(code_valid_o), 32'd0);
        chk("ff0_err", 32'(err_seen), 32'd1);

        // 3-cycle clock glitch while idle
        busy_seen = 0;
        ps2_clk_i = 1'b0;
        wait_cyc(3);
        ps2_clk_i = 1'b1;
        wait_cyc(30);
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        chk("glitch_err", 32'(err_seen), 32'd1);
        chk("glitch_valid", 32'(code_valid_o), 32'd0);

        // Timeout after start + 4 data bits
        send_bits(8'h5A, 1'b0, 5, 20);
        chk("tmo_busy_in", 32'(busy_o), 32'd1);
        wait_cyc(25100);
        chk("tmo_err", 32'(err_seen), 32'd2);
        chk("tmo_busy_out", 32'(busy_o), 32'd0);
        send_bits(8'h5A, 1'b0, 11, 20);
        wait_cyc(30);
        pop_chk("f5a", 8'h5A);
        chk("f5a_err", 32'(err_seen), 32'd2);

        // Overflow on the 9th frame
        ovf_seen = 0;
        for (int i = 1; i <= 8; i++) send_bits(8'(i), 1'b0, 11, 20);
        wait_cyc(30);
        chk("ovf_before9", 32'(ovf_seen), 32'd0);
        send_bits(8'h09, 1'b0, 11, 20);
        wait_cyc(30);
        chk("ovf_on9", 32'(ovf_seen), 32'd1);
        chk("ovf_err", 32'(err_seen), 32'd2);
        for (int i = 1; i <= 8; i++) pop_chk("ovf_drain", 8'(i));
        chk("ovf_drained", 32'(code_valid_o), 32'd0);
`ifdef PS2_RX_ERRCNT_EN
        chk("errcnt", 32'(err_count_o), 32'd3);
`endif

        // Full FIFO with a pop coincident with the push of 8'h77
        ovf_seen = 0;
        for (int i = 1; i <= 8; i++) send_bits(8'(i), 1'b0, 11, 20);
        send_bits(8'h77, 1'b0, 10, 20);
        ps2_data_i = 1'b1;
        wait_cyc(20);
        ps2_clk_i = 1'b0;
        wait_cyc(11);
        code_ready_i = 1'b1;
        wait_cyc(1);
        code_ready_i = 1'b0;
        wait_cyc(8);
        ps2_clk_i = 1'b1;
        wait_cyc(30);
        chk("fpop_noovf", 32'(ovf_seen), 32'd0);
        for (int i = 2; i <= 8; i++) pop_chk("fpop_drain", 8'(i));
        pop_chk("fpop_last", 8'h77);
        chk("fpop_empty", 32'(code_valid_o), 32'd0);

        // Reset mid-frame: partial frame discarded, no error pulse
        send_bits(8'h33, 1'b0, 5, 20);
        chk("mrst_busy_in", 32'(busy_o), 32'd1);
        reset_in = 1'b1;
        wait_cyc(3);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_valid", 32'(code_valid_o), 32'd0);
        chk("mrst_code", 32'(code_o), 32'h00);
        chk("mrst_errpin", 32'(frame_err_o), 32'd0);
        chk("mrst_ovfpin", 32'(overflow_o), 32'd0);
        reset_in = 1'b0;
        wait_cyc(50);
        chk("mrst_noerr", 32'(err_seen), 32'd2);
        chk("mrst_busy_after", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
